axi_mm_write: RTL and testbench



---
 rtl/axi_mm_write_if.sv | 68 ++++++
 rtl/axi_mm_write.sv | 181 ++++++++++++++++++
 tb/tb_axi_mm_write.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mm_write_if.sv
// Bus bundle for axi_mm_write: AXI4 AW/W/B channels plus the core-side request and data stream.
// Latency: n/a (wiring only).
// Backpressure: n/a; master modport is the write engine's view, slave modport the interconnect/core view.
interface axi_mm_write_if #(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32
);
    // AXI write address channel
    logic [3:0]              awid;
    logic [AXI_AWIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    // AXI write data channel
    logic [AXI_DWIDTH-1:0]   wdata;
    logic [AXI_DWIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic                    wlast;
    // AXI write response channel
    logic [3:0]              bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    // Core request
    logic                    core_write_request_valid;
    logic                    core_write_request_ready;
    logic [AXI_AWIDTH-1:0]   core_write_addr;
    logic [31:0]             core_write_len;
    logic [2:0]              core_write_size;
    logic [1:0]              core_write_burst;
    // Core data stream and status
    logic [AXI_DWIDTH-1:0]   core_write_data;
    logic                    core_write_data_valid;
    logic                    core_write_data_ready;
    logic                    core_write_done;
    logic                    core_write_error;

    modport master (
        output awid, awaddr, awvalid, awlen, awsize, awburst,
        input  awready,
        output wdata, wstrb, wvalid, wlast,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        input  core_write_request_valid, core_write_addr, core_write_len,
        input  core_write_size, core_write_burst,
        output core_write_request_ready,
        input  core_write_data, core_write_data_valid,
        output core_write_data_ready, core_write_done, core_write_error
    );

    modport slave (
        input  awid, awaddr, awvalid, awlen, awsize, awburst,
        output awready,
        input  wdata, wstrb, wvalid, wlast,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        output core_write_request_valid, core_write_addr, core_write_len,
        output core_write_size, core_write_burst,
        input  core_write_request_ready,
        output core_write_data, core_write_data_valid,
        input  core_write_data_ready, core_write_done, core_write_error
    );
endinterface

// File: rtl/axi_mm_write.sv
// AXI4 write master: one core request -> AW/W/B sub-bursts of at most AXI_MAX_BURST_LEN beats, done pulse at end.
// Latency: AW valid one cycle after request accept; next AW one cycle after each B; done one cycle after final B.
// Backpressure: W data passes through combinationally (wready -> core_write_data_ready); AW/B wait on awready/bvalid.
// Optional: define AXI_MM_WRITE_RESP_ERR_EN to report non-OKAY bresp on core_write_error.
module axi_mm_write #(
    parameter int AXI_AWIDTH        = 32,
    parameter int AXI_DWIDTH        = 32,
    parameter int AXI_MAX_BURST_LEN = 256
) (
    input  logic            clk,
    input  logic            resetn,
    axi_mm_write_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    localparam logic [31:0]           MAX_LEN    = 32'(AXI_MAX_BURST_LEN);
    localparam logic [31:0]           MAX_M1     = 32'(AXI_MAX_BURST_LEN - 1);
    localparam logic [AXI_AWIDTH-1:0] MAX_BEATSA = AXI_AWIDTH'(AXI_MAX_BURST_LEN);

    state_t                state_q, state_d;
    logic [AXI_AWIDTH-1:0] addr_q, addr_d;
    logic [31:0]           rem_q, rem_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [7:0]            beat_q, beat_d;

    // Handshake outputs are registered so they sit at 0 throughout reset.
    logic req_rdy_q, awvalid_q, bready_q, done_q;

    logic       more_bursts;
    logic [7:0] awlen_w;
    logic       in_w, wlast_w;
    logic       req_fire, aw_fire, w_fire, b_fire;

    // Sub-burst length follows the remaining beat count; rem only changes on B, so awlen holds through AW.
    assign more_bursts = (rem_q > MAX_M1);
    assign awlen_w     = more_bursts ? MAX_M1[7:0] : rem_q[7:0];

    assign in_w    = (state_q == S_W);
    assign wlast_w = in_w && (beat_q == awlen_w);

    assign req_fire = req_rdy_q && bus.core_write_request_valid;
    assign aw_fire  = awvalid_q && bus.awready;
    assign w_fire   = in_w && bus.core_write_data_valid && bus.wready;
    assign b_fire   = bready_q && bus.bvalid;

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state and datapath update: one sub-burst in flight, split on MAX boundaries.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        size_d  = size_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    addr_d  = bus.core_write_addr;
                    rem_d   = bus.core_write_len;
                    size_d  = bus.core_write_size;
                    burst_d = bus.core_write_burst;
                    state_d = S_AW;
                end
            end
            S_AW: begin
                if (aw_fire) begin
                    beat_d  = '0;
                    state_d = S_W;
                end
            end
            S_W: begin
                if (w_fire) begin
                    beat_d = beat_q + 8'd1;
                    if (wlast_w) begin
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                if (b_fire) begin
                    if (more_bursts) begin
                        rem_d   = rem_q - MAX_LEN;
                        addr_d  = addr_q + (MAX_BEATSA << size_q);
                        state_d = S_AW;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered Moore outputs decoded from the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_rdy_q <= 1'b0;
            awvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            req_rdy_q <= (state_d == S_IDLE);
            awvalid_q <= (state_d == S_AW);
            bready_q  <= (state_d == S_B);
            done_q    <= (state_d == S_DONE);
        end
    end

`ifdef AXI_MM_WRITE_RESP_ERR_EN
    logic err_q;

    // Sticky error across all sub-bursts of a request; a new request clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (req_fire) begin
            err_q <= 1'b0;
        end else if (b_fire && (bus.bresp != 2'b00)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.core_write_error = err_q;

    logic unused_bid;
    assign unused_bid = ^bus.bid;
`else
    assign bus.core_write_error = 1'b0;

    logic unused_bresp;
    assign unused_bresp = ^{bus.bid, bus.bresp};
`endif

    assign bus.awid    = 4'd0;
    assign bus.awaddr  = addr_q;
    assign bus.awvalid = awvalid_q;
    assign bus.awlen   = awlen_w;
    assign bus.awsize  = size_q;
    assign bus.awburst = burst_q;

    assign bus.wdata  = bus.core_write_data;
    assign bus.wstrb  = '1;
    assign bus.wvalid = in_w && bus.core_write_data_valid;
    assign bus.wlast  = wlast_w;

    assign bus.bready = bready_q;

    assign bus.core_write_request_ready = req_rdy_q;
    assign bus.core_write_data_ready    = in_w && bus.wready;
    assign bus.core_write_done          = done_q;
endmodule

// File: tb/tb_axi_mm_write.sv
module tb_axi_mm_write;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    axi_mm_write_if #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) bus ();

    axi_mm_write #(
        .AXI_AWIDTH(32),
        .AXI_DWIDTH(32),
        .AXI_MAX_BURST_LEN(256)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus.master)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Per-transaction capture
    logic [31:0] q_awaddr[$];
    logic [7:0]  q_awlen[$];
    logic [2:0]  q_awsize[$];
    logic [1:0]  q_awburst[$];
    int          q_last[$];
    int n_beats, data_err, proto_err, const_err, aw_unstable, aw_hold;
    int done_cnt, done_lat;
    logic err_at_done, ready_after;

    task automatic idle_inputs();
        bus.awready = 1'b0;
        bus.wready = 1'b0;
        bus.bvalid = 1'b0;
        bus.bresp = 2'b00;
        bus.bid = 4'd0;
        bus.core_write_request_valid = 1'b0;
        bus.core_write_addr = '0;
        bus.core_write_len = '0;
        bus.core_write_size = '0;
        bus.core_write_burst = '0;
        bus.core_write_data = '0;
        bus.core_write_data_valid = 1'b0;
    endtask

    task automatic send_req(input logic [31:0] addr, input logic [31:0] len, input logic [2:0] size);
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            bus.core_write_request_valid = 1'b1;
            bus.core_write_addr = addr;
            bus.core_write_len = len;
            bus.core_write_size = size;
            bus.core_write_burst = 2'b01;
            #4;
            ok = (bus.core_write_request_ready === 1'b1);
        end
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL req_accept_timeout ready=%b want 1", bus.core_write_request_ready);
        end
    endtask

    // Drive one request and act as core data source and AXI slave until done is seen.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] len, input logic [2:0] size,
                           input int awstall, input bit stall, input logic [1:0] bresp0,
                           input logic [31:0] base);
        int aw_wait = 0, burst_idx = 0, cyc = 0, last_b_cyc = -100, done_cyc = 0;
        int data_idx = 0;
        bit aw_open = 0, b_pending = 0, prev_wait = 0, finished = 0;
        logic [31:0] prev_addr;
        logic [7:0]  prev_len;
        bit wf, df;
        q_awaddr.delete(); q_awlen.delete(); q_awsize.delete(); q_awburst.delete(); q_last.delete();
        n_beats = 0; data_err = 0; proto_err = 0; const_err = 0; aw_unstable = 0; aw_hold = 0;
        done_cnt = 0; done_lat = -1; err_at_done = 1'bx; ready_after = 1'bx;
        send_req(addr, len, size);
        while (!finished && cyc < 4000) begin
            @(negedge clk);
            bus.core_write_request_valid = 1'b0;
            bus.awready = bus.awvalid && (aw_wait >= awstall);
            bus.wready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (data_idx <= int'(len)) begin
                bus.core_write_data_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.core_write_data = base + 32'(data_idx);
            end else begin
                bus.core_write_data_valid = 1'b0;
            end
            bus.bvalid = b_pending;
            bus.bresp = (burst_idx == 0) ? bresp0 : 2'b00;
            #4;
            if (bus.awvalid && prev_wait && (bus.awaddr !== prev_addr || bus.awlen !== prev_len))
                aw_unstable++;
            prev_wait = 0;
            if (bus.awvalid && !bus.awready) begin
                aw_wait++; aw_hold++; prev_wait = 1;
                prev_addr = bus.awaddr; prev_len = bus.awlen;
            end
            if (bus.awvalid && bus.awready) begin
                q_awaddr.push_back(bus.awaddr); q_awlen.push_back(bus.awlen);
                q_awsize.push_back(bus.awsize); q_awburst.push_back(bus.awburst);
                if (bus.awid !== 4'd0) const_err++;
                aw_open = 1; aw_wait = 0;
            end
            if (bus.wvalid && !aw_open) proto_err++;
            wf = bus.wvalid && bus.wready;
            df = bus.core_write_data_valid && bus.core_write_data_ready;
            if (wf !== df) proto_err++;
            if (wf) begin
                if (bus.wdata !== base + 32'(data_idx)) data_err++;
                if (bus.wstrb !== 4'hF) const_err++;
                if (bus.wlast) begin
                    q_last.push_back(data_idx);
                    aw_open = 0; b_pending = 1;
                end
                data_idx++; n_beats++;
            end
            if (bus.bvalid && bus.bready) begin
                b_pending = 0; burst_idx++; last_b_cyc = cyc;
            end
            if (bus.core_write_done) begin
                done_cnt++; done_cyc = cyc; done_lat = cyc - last_b_cyc;
                err_at_done = bus.core_write_error;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 2) begin
                ready_after = bus.core_write_request_ready;
                finished = 1;
            end
            cyc++;
        end
        idle_inputs();
        tests_run++;
        if (!finished) begin
            tests_failed++;
            $display("FAIL txn_timeout beats=%0d done=%0d after %0d cycles", n_beats, done_cnt, cyc);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({bus.awvalid, bus.wvalid, bus.bready, bus.core_write_done} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_valids aw/w/b/done=%b want 0000",
                     {bus.awvalid, bus.wvalid, bus.bready, bus.core_write_done});
        end
        tests_run++;
        if ({bus.core_write_request_ready, bus.core_write_data_ready, bus.core_write_error} !== 3'b0) begin
            tests_failed++;
            $display("FAIL reset_core req_rdy/data_rdy/err=%b want 000",
                     {bus.core_write_request_ready, bus.core_write_data_ready, bus.core_write_error});
        end
        tests_run++;
        if ({bus.awaddr, bus.awlen, bus.awsize, bus.awburst} !== 45'd0) begin
            tests_failed++;
            $display("FAIL reset_regs awaddr=%h awlen=%0d awsize=%0d awburst=%0d want 0",
                     bus.awaddr, bus.awlen, bus.awsize, bus.awburst);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #4;
        tests_run++;
        if (bus.core_write_request_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready got %b want 1", bus.core_write_request_ready);
        end
    endtask

    task automatic test_single();
        run_txn(32'h1000, 32'd3, 3'd2, 0, 1'b0, 2'b00, 32'hA000_0000);
        tests_run++;
        if (q_awaddr.size() !== 1 || q_awaddr[0] !== 32'h1000 || q_awlen[0] !== 8'd3) begin
            tests_failed++;
            $display("FAIL single_aw count=%0d addr=%h len=%0d want 1 00001000 3",
                     q_awaddr.size(), q_awaddr[0], q_awlen[0]);
        end
        tests_run++;
        if (q_awsize[0] !== 3'd2 || q_awburst[0] !== 2'b01 || const_err !== 0) begin
            tests_failed++;
            $display("FAIL single_attr size=%0d burst=%0d id/strb_err=%0d want 2 1 0",
                     q_awsize[0], q_awburst[0], const_err);
        end
        tests_run++;
        if (n_beats !== 4 || data_err !== 0 || q_last.size() !== 1 || q_last[0] !== 3) begin
            tests_failed++;
            $display("FAIL single_w beats=%0d data_err=%0d nlast=%0d last_at=%0d want 4 0 1 3",
                     n_beats, data_err, q_last.size(), q_last[0]);
        end
        tests_run++;
        if (done_cnt !== 1 || done_lat !== 1 || ready_after !== 1'b1 || proto_err !== 0) begin
            tests_failed++;
            $display("FAIL single_done pulses=%0d lat=%0d ready_after=%b proto=%0d want 1 1 1 0",
                     done_cnt, done_lat, ready_after, proto_err);
        end
    endtask

    task automatic test_multi_burst();
        run_txn(32'h1000, 32'd599, 3'd2, 0, 1'b0, 2'b00, 32'hB000_0000);
        tests_run++;
        if (q_awaddr.size() !== 3 || q_awaddr[0] !== 32'h1000 || q_awaddr[1] !== 32'h1400
            || q_awaddr[2] !== 32'h1800) begin
            tests_failed++;
            $display("FAIL multi_awaddr count=%0d %h %h %h want 3 00001000 00001400 00001800",
                     q_awaddr.size(), q_awaddr[0], q_awaddr[1], q_awaddr[2]);
        end
        tests_run++;
        if (q_awlen[0] !== 8'd255 || q_awlen[1] !== 8'd255 || q_awlen[2] !== 8'd87) begin
            tests_failed++;
            $display("FAIL multi_awlen %0d %0d %0d want 255 255 87", q_awlen[0], q_awlen[1], q_awlen[2]);
        end
        tests_run++;
        if (n_beats !== 600 || data_err !== 0 || q_last.size() !== 3 || q_last[0] !== 255
            || q_last[1] !== 511 || q_last[2] !== 599) begin
            tests_failed++;
            $display("FAIL multi_w beats=%0d data_err=%0d nlast=%0d want 600 0 3 (255/511/599)",
                     n_beats, data_err, q_last.size());
        end
        tests_run++;
        if (done_cnt !== 1 || done_lat !== 1 || proto_err !== 0) begin
            tests_failed++;
            $display("FAIL multi_done pulses=%0d lat=%0d proto=%0d want 1 1 0", done_cnt, done_lat, proto_err);
        end
    endtask

    task automatic test_len0_awstall();
        run_txn(32'h3000, 32'd0, 3'd2, 5, 1'b0, 2'b00, 32'hC000_0000);
        tests_run++;
        if (aw_hold !== 5 || aw_unstable !== 0) begin
            tests_failed++;
            $display("FAIL len0_aw_hold held=%0d unstable=%0d want 5 0", aw_hold, aw_unstable);
        end
        tests_run++;
        if (q_awaddr.size() !== 1 || q_awaddr[0] !== 32'h3000 || q_awlen[0] !== 8'd0) begin
            tests_failed++;
            $display("FAIL len0_aw count=%0d addr=%h len=%0d want 1 00003000 0",
                     q_awaddr.size(), q_awaddr[0], q_awlen[0]);
        end
        tests_run++;
        if (n_beats !== 1 || q_last.size() !== 1 || q_last[0] !== 0 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL len0_w beats=%0d nlast=%0d last_at=%0d done=%0d want 1 1 0 1",
                     n_beats, q_last.size(), q_last[0], done_cnt);
        end
    endtask

    task automatic test_stalls();
        run_txn(32'h4000, 32'd255, 3'd2, 2, 1'b1, 2'b00, 32'hD000_0000);
        tests_run++;
        if (n_beats !== 256 || data_err !== 0) begin
            tests_failed++;
            $display("FAIL stall_data beats=%0d data_err=%0d want 256 0", n_beats, data_err);
        end
        tests_run++;
        if (q_last.size() !== 1 || q_last[0] !== 255 || q_awaddr.size() !== 1 || q_awlen[0] !== 8'd255) begin
            tests_failed++;
            $display("FAIL stall_wlast nlast=%0d last_at=%0d naw=%0d awlen=%0d want 1 255 1 255",
                     q_last.size(), q_last[0], q_awaddr.size(), q_awlen[0]);
        end
        tests_run++;
        if (proto_err !== 0 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL stall_proto proto=%0d done=%0d want 0 1", proto_err, done_cnt);
        end
    endtask

    task automatic test_resp_error();
        logic exp_err;
`ifdef AXI_MM_WRITE_RESP_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        run_txn(32'h2000, 32'd300, 3'd2, 0, 1'b0, 2'b10, 32'hE000_0000);
        tests_run++;
        if (q_awaddr.size() !== 2 || q_awaddr[1] !== 32'h2400 || q_awlen[1] !== 8'd44 || n_beats !== 301) begin
            tests_failed++;
            $display("FAIL err_second_burst naw=%0d addr1=%h len1=%0d beats=%0d want 2 00002400 44 301",
                     q_awaddr.size(), q_awaddr[1], q_awlen[1], n_beats);
        end
        tests_run++;
        if (err_at_done !== exp_err || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL err_flag got %b done=%0d want %b 1", err_at_done, done_cnt, exp_err);
        end
        run_txn(32'h5000, 32'd0, 3'd2, 0, 1'b0, 2'b00, 32'hE100_0000);
        tests_run++;
        if (err_at_done !== 1'b0 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL err_cleared got %b done=%0d want 0 1", err_at_done, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        logic wv_before;
        send_req(32'h6000, 32'd7, 3'd2);
        for (int c = 0; c < 50 && beats < 2; c++) begin
            @(negedge clk);
            bus.core_write_request_valid = 1'b0;
            bus.awready = 1'b1;
            bus.wready = 1'b1;
            bus.core_write_data_valid = 1'b1;
            bus.core_write_data = 32'hF000_0000 + 32'(beats);
            #4;
            if (bus.wvalid && bus.wready) beats++;
        end
        @(negedge clk);
        #1;
        wv_before = bus.wvalid;
        #1;
        resetn = 1'b0;
        #1;
        tests_run++;
        if (wv_before !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_in_w wvalid_before=%b want 1", wv_before);
        end
        tests_run++;
        if ({bus.awvalid, bus.wvalid, bus.bready, bus.core_write_data_ready,
             bus.core_write_request_ready, bus.core_write_done} !== 6'b0) begin
            tests_failed++;
            $display("FAIL midreset_outputs aw/w/b/drdy/rrdy/done=%b want 000000",
                     {bus.awvalid, bus.wvalid, bus.bready, bus.core_write_data_ready,
                      bus.core_write_request_ready, bus.core_write_done});
        end
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #4;
        tests_run++;
        if (bus.core_write_request_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_ready got %b want 1", bus.core_write_request_ready);
        end
        run_txn(32'h7000, 32'd1, 3'd2, 0, 1'b0, 2'b00, 32'h1234_0000);
        tests_run++;
        if (q_awaddr.size() !== 1 || q_awaddr[0] !== 32'h7000 || q_awlen[0] !== 8'd1 || n_beats !== 2
            || data_err !== 0 || q_last.size() !== 1 || q_last[0] !== 1 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL midreset_next naw=%0d addr=%h len=%0d beats=%0d derr=%0d done=%0d want 1 00007000 1 2 0 1",
                     q_awaddr.size(), q_awaddr[0], q_awlen[0], n_beats, data_err, done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_burst();
        test_len0_awstall();
        test_stalls();
        test_resp_error();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
